// File: rtl/encrypt_pipe_pkg.sv
// encrypt_pipe_pkg: shared types and widths for the encrypt pipeline controller.
// Provides the controller state enum, the bundled frame configuration struct,
// and the byte / shift / rotation-frequency widths.
package encrypt_pipe_pkg;

    localparam int BYTE_W  = 8;
    localparam int SHIFT_W = 4;
    localparam int ROT_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic               mode;
        logic               shift_en;
        logic [SHIFT_W-1:0] shift_amt;
        logic [BYTE_W-1:0]  k1;
        logic [BYTE_W-1:0]  k2;
        logic [BYTE_W-1:0]  k3;
        logic [ROT_W-1:0]   rot_freq;
    } cfg_t;

endpackage

// File: rtl/encrypt_pipe_rot_ctr.sv
// encrypt_pipe_rot_ctr: per-frame shift amount with periodic stepping.
// Ports: clk, rst (async active-low), load/init_amt (start of frame),
// rot_freq (bytes per step, 0 = never step), step (byte accepted),
// shift_amt (current shift amount, wraps 15 -> 0).
module encrypt_pipe_rot_ctr
    import encrypt_pipe_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [SHIFT_W-1:0] init_amt,
    input  logic [ROT_W-1:0]   rot_freq,
    input  logic               step,
    output logic [SHIFT_W-1:0] shift_amt
);

    logic [ROT_W-1:0] rot_cnt;
    logic             pend;
    logic             wrap;

    assign wrap = rot_cnt == rot_freq - ROT_W'(1);

    // The increment earned by a byte is held in pend and applied on the next
    // accepted byte, so it shows up together with that successor's pipe_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rot_cnt   <= '0;
            pend      <= 1'b0;
            shift_amt <= '0;
        end else if (load) begin
            rot_cnt   <= '0;
            pend      <= 1'b0;
            shift_amt <= init_amt;
        end else if (step && rot_freq != '0) begin
            shift_amt <= shift_amt + SHIFT_W'(pend);
            pend      <= wrap;
            rot_cnt   <= wrap ? '0 : rot_cnt + ROT_W'(1);
        end
    end

endmodule

// File: rtl/encrypt_pipe_ctrl.sv
// encrypt_pipe_ctrl: frame sequencer in front of the compare/scramble pipe.
// Ports: clk, rst (async active-low); cfg_* valid/ready config accept;
// s_* valid/ready byte stream; pipe_* registered byte and held config;
// busy, done (one-cycle frame-end pulse), byte_cnt (bytes accepted).
// Build option CTRL_ABORT_EN adds an abort input that ends a frame early.
module encrypt_pipe_ctrl
    import encrypt_pipe_pkg::*;
#(
    parameter int LEN_W      = 16,
    parameter int PIPE_DEPTH = 3,
    parameter int DRAIN_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef CTRL_ABORT_EN
    input  logic               abort,
`endif
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic               cfg_mode,
    input  logic               cfg_shift_en,
    input  logic [SHIFT_W-1:0] cfg_shift_amt,
    input  logic [BYTE_W-1:0]  cfg_k1,
    input  logic [BYTE_W-1:0]  cfg_k2,
    input  logic [BYTE_W-1:0]  cfg_k3,
    input  logic [ROT_W-1:0]   cfg_rot_freq,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [BYTE_W-1:0]  s_data,
    output logic               pipe_en,
    output logic [BYTE_W-1:0]  pipe_din,
    output logic               pipe_mode,
    output logic               pipe_shift_en,
    output logic [SHIFT_W-1:0] pipe_shift_amt,
    output logic [BYTE_W-1:0]  pipe_k1,
    output logic [BYTE_W-1:0]  pipe_k2,
    output logic [BYTE_W-1:0]  pipe_k3,
    output logic [ROT_W-1:0]   pipe_rot_freq,
    output logic               busy,
    output logic               done,
    output logic [LEN_W-1:0]   byte_cnt
);

    ctrl_state_t        state, state_nxt;
    cfg_t               cfg_in;
    logic [LEN_W-1:0]   len_q;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               cfg_acc;
    logic               hs;
    logic               last;
    logic               abort_run;

    assign cfg_in = '{cfg_mode, cfg_shift_en, cfg_shift_amt, cfg_k1, cfg_k2, cfg_k3, cfg_rot_freq};

    assign cfg_ready = state == IDLE;
    assign s_ready   = state == RUN;
    assign busy      = state != IDLE;
    assign done      = state == DONE;

`ifdef CTRL_ABORT_EN
    assign abort_run = abort && state == RUN;
`else
    assign abort_run = 1'b0;
`endif

    // Abort wins over a same-cycle byte: that byte is simply not accepted.
    assign cfg_acc = cfg_valid && cfg_ready;
    assign hs      = s_valid && s_ready && !abort_run;
    assign last    = hs && byte_cnt == len_q - LEN_W'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = cfg_acc ? (cfg_len != '0 ? RUN : DONE) : IDLE;
            RUN:     state_nxt = (last || abort_run) ? DRAIN : RUN;
            DRAIN:   state_nxt = drain_cnt == '0 ? DONE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    // The drain counter is kept at PIPE_DEPTH throughout RUN, so it holds that
    // value on the first DRAIN cycle without a dedicated entry strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            len_q         <= '0;
            drain_cnt     <= '0;
            byte_cnt      <= '0;
            pipe_en       <= 1'b0;
            pipe_din      <= '0;
            pipe_mode     <= 1'b0;
            pipe_shift_en <= 1'b0;
            pipe_k1       <= '0;
            pipe_k2       <= '0;
            pipe_k3       <= '0;
            pipe_rot_freq <= '0;
        end else begin
            state     <= state_nxt;
            pipe_en   <= hs;
            drain_cnt <= state == RUN ? DRAIN_W'(PIPE_DEPTH) :
                         (state == DRAIN && drain_cnt != '0) ? drain_cnt - DRAIN_W'(1) : drain_cnt;
            if (hs) begin
                pipe_din <= s_data;
                byte_cnt <= byte_cnt + LEN_W'(1);
            end
            if (cfg_acc) begin
                len_q         <= cfg_len;
                byte_cnt      <= '0;
                pipe_mode     <= cfg_in.mode;
                pipe_shift_en <= cfg_in.shift_en;
                pipe_k1       <= cfg_in.k1;
                pipe_k2       <= cfg_in.k2;
                pipe_k3       <= cfg_in.k3;
                pipe_rot_freq <= cfg_in.rot_freq;
            end
        end
    end

    encrypt_pipe_rot_ctr u_rot (
        .clk      (clk),
        .rst      (rst),
        .load     (cfg_acc),
        .init_amt (cfg_in.shift_amt),
        .rot_freq (pipe_rot_freq),
        .step     (hs),
        .shift_amt(pipe_shift_amt)
    );

endmodule

// File: tb/tb_encrypt_pipe_ctrl.sv
// tb_encrypt_pipe_ctrl: self-checking bench for encrypt_pipe_ctrl.
module tb_encrypt_pipe_ctrl;
    import encrypt_pipe_pkg::*;

    localparam int LEN_W      = 16;
    localparam int PIPE_DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             abort = 1'b0;
    logic             cfg_valid = 1'b0, cfg_ready;
    logic             cfg_mode = 1'b0, cfg_shift_en = 1'b0;
    logic [3:0]       cfg_shift_amt = '0;
    logic [7:0]       cfg_k1 = '0, cfg_k2 = '0, cfg_k3 = '0;
    logic [2:0]       cfg_rot_freq = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             s_valid = 1'b0, s_ready;
    logic [7:0]       s_data = '0;
    logic             pipe_en, pipe_mode, pipe_shift_en, busy, done;
    logic [7:0]       pipe_din, pipe_k1, pipe_k2, pipe_k3;
    logic [3:0]       pipe_shift_amt;
    logic [2:0]       pipe_rot_freq;
    logic [LEN_W-1:0] byte_cnt;

    always #5 clk = ~clk;

    encrypt_pipe_ctrl #(.LEN_W(LEN_W), .PIPE_DEPTH(PIPE_DEPTH), .DRAIN_W(4)) dut (
        .clk(clk), .rst(rst),
`ifdef CTRL_ABORT_EN
        .abort(abort),
`endif
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
        .cfg_shift_en(cfg_shift_en), .cfg_shift_amt(cfg_shift_amt),
        .cfg_k1(cfg_k1), .cfg_k2(cfg_k2), .cfg_k3(cfg_k3),
        .cfg_rot_freq(cfg_rot_freq), .cfg_len(cfg_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .pipe_en(pipe_en), .pipe_din(pipe_din), .pipe_mode(pipe_mode),
        .pipe_shift_en(pipe_shift_en), .pipe_shift_amt(pipe_shift_amt),
        .pipe_k1(pipe_k1), .pipe_k2(pipe_k2), .pipe_k3(pipe_k3),
        .pipe_rot_freq(pipe_rot_freq), .busy(busy), .done(done), .byte_cnt(byte_cnt)
    );

    typedef struct { logic [7:0] data; logic [3:0] shift; } exp_t;
    typedef struct { int len; int rot; int amt; bit gappy; int exp_cnt; } frame_t;

    exp_t   sb[$];
    frame_t tbl[5];
    int     passed = 0, total = 0, cyc = 0, pe_cnt = 0, last_pe = -1;
    logic [7:0] k1_exp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else passed++;
    endtask

    function automatic logic [3:0] exp_shift(input int amt, input int rot, input int i);
        int s;
        s = amt + (rot != 0 ? i / rot : 0);
        return 4'(s % 16);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every pipe_en must match the oldest accepted byte.
    always @(negedge clk) begin
        exp_t e;
        if (rst && pipe_en) begin
            pe_cnt++;
            last_pe = cyc;
            if (sb.size() == 0) chk("pipe_en_unexpected", {24'd0, pipe_din}, 32'hFFFF_FFFF);
            else begin
                e = sb.pop_front();
                chk("pipe_din", pipe_din, e.data);
                chk("pipe_shift_amt", pipe_shift_amt, e.shift);
            end
        end
    end

    task automatic send_cfg(input int len, input int rot, input int amt);
        @(negedge clk);
        chk("cfg_ready_idle", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_mode = 1'b1; cfg_shift_en = 1'b1;
        cfg_shift_amt = amt[3:0]; cfg_rot_freq = rot[2:0]; cfg_len = len[LEN_W-1:0];
        k1_exp = 8'($urandom); cfg_k1 = k1_exp; cfg_k2 = 8'($urandom); cfg_k3 = 8'($urandom);
        pe_cnt = 0;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        chk("pipe_k1_loaded", pipe_k1, k1_exp);
        chk("pipe_rot_freq_loaded", pipe_rot_freq, rot[2:0]);
        chk("byte_cnt_cleared", byte_cnt, 0);
    endtask

    task automatic send_bytes(input int n, input int rot, input int amt, input bit gappy);
        int sent = 0, budget = 0;
        bit ph = 1'b1;
        while (sent < n && budget < 200) begin
            @(negedge clk);
            budget++;
            s_valid = gappy ? ph : 1'b1;
            ph = ~ph;
            s_data = 8'($urandom);
            if (s_valid && s_ready) begin
                sb.push_back('{s_data, exp_shift(amt, rot, sent)});
                sent++;
            end
        end
        if (sent < n) chk("send_budget", sent, n);
    endtask

    task automatic wait_done(input int exp_cnt, input int exp_pe, input bit lat, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 50);
        if (!done) chk("done_timeout", 0, 1);
        else begin
            if (lat) chk("done_latency", cyc - last_pe, PIPE_DEPTH + 1);
            chk("byte_cnt_done", byte_cnt, exp_cnt);
            chk("pipe_en_count", pe_cnt, exp_pe);
            chk("scoreboard_empty", sb.size(), 0);
            chk("busy_in_done", busy, 1);
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("cfg_ready_after", cfg_ready, 1);
            chk("byte_cnt_hold", byte_cnt, exp_cnt);
            chk("pipe_k1_hold", pipe_k1, k1_exp);
        end
    endtask

    task automatic run_frame(input frame_t f);
        int n;
        send_cfg(f.len, f.rot, f.amt);
        if (f.len == 0) begin
            wait_done(0, 0, 1'b0, n);
            chk("zero_len_done_delay", n, 1);
        end else begin
            send_bytes(f.len, f.rot, f.amt, f.gappy);
            @(negedge clk);
            s_valid = 1'b1;
            chk("s_ready_after_last", s_ready, 0);
            wait_done(f.exp_cnt, f.len, 1'b1, n);
            s_valid = 1'b0;
        end
    endtask

    initial begin
        int n;
        tbl[0] = '{4, 0, 4, 1'b0, 4};
        tbl[1] = '{3, 1, 7, 1'b1, 3};
        tbl[2] = '{6, 2, 14, 1'b0, 6};
        tbl[3] = '{0, 0, 9, 1'b0, 0};
        tbl[4] = '{5, 3, 15, 1'b1, 5};

        repeat (2) @(negedge clk);
        chk("reset_cfg_ready", cfg_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_pipe_en", pipe_en, 0);
        chk("reset_byte_cnt", byte_cnt, 0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) run_frame(tbl[i]);

        send_cfg(8, 1, 3);
        send_bytes(2, 1, 3, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_pipe_en", pipe_en, 0);
        chk("rst_byte_cnt", byte_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_pipe_din", pipe_din, 0);
        chk("rst_pipe_k1", pipe_k1, 0);
        chk("rst_pipe_shift_amt", pipe_shift_amt, 0);
        sb.delete();
        s_valid = 1'b0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            n += done;
        end
        chk("rst_no_done", n, 0);
        rst = 1'b1;

        run_frame(tbl[0]);

`ifdef CTRL_ABORT_EN
        send_cfg(10, 0, 5);
        send_bytes(3, 0, 5, 1'b0);
        @(negedge clk);
        chk("s_ready_before_abort", s_ready, 1);
        s_valid = 1'b1; s_data = 8'hEE; abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0; s_valid = 1'b0;
        wait_done(3, 3, 1'b0, n);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/encrypt_pipe_ctrl.md
Name: encrypt_pipe_ctrl

Overview:
Sequencer in front of the encrypt pipeline (data-compare stage feeding the scramble stage). It accepts one configuration per frame over a valid/ready handshake and holds it stable on the pipe config ports. It then streams exactly cfg_len bytes into the pipe with a valid/ready byte handshake, stepping shift_amt every rot_freq bytes. After the last byte it drains for the pipe latency and pulses done.

Parameters:
LEN_W, 16, width of frame length and byte counter
PIPE_DEPTH, 3, cycles from pipe_en of the last byte until its result leaves the scramble stage
DRAIN_W, 4, width of drain counter; must satisfy PIPE_DEPTH < 2**DRAIN_W

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  controller accepts configuration (high only in IDLE)
cfg_mode  input  1  1=encrypt, 0=decrypt
cfg_shift_en  input  1  enable shift
cfg_shift_amt  input  4  initial shift amount
cfg_k1, cfg_k2, cfg_k3  input  8 each  keys
cfg_rot_freq  input  3  bytes per shift step; 0 = no stepping
cfg_len  input  LEN_W  bytes in frame
s_valid  input  1  input byte valid
s_ready  output  1  controller accepts byte (high only in RUN)
s_data  input  8  input byte
pipe_en  output  1  byte valid into pipe
pipe_din  output  8  byte into pipe
pipe_mode, pipe_shift_en  output  1 each  held config
pipe_shift_amt  output  4  current shift amount
pipe_k1, pipe_k2, pipe_k3  output  8 each  held keys
pipe_rot_freq  output  3  held rot_freq
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at frame end
byte_cnt  output  LEN_W  bytes accepted in current frame

Behaviour:
- Reset (rst low, async): state IDLE; all outputs and internal registers 0; cfg_ready=1 (combinational from state).
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on cfg_valid&&cfg_ready, register all cfg_* into the pipe_* registers and cfg_len; clear byte_cnt and rot_cnt. Next state is RUN if cfg_len!=0, otherwise DONE.
- RUN: s_ready=1. On s_valid&&s_ready, next cycle pipe_en=1 and pipe_din=s_data (1-cycle registered latency); byte_cnt+1. Without a handshake, pipe_en=0 and pipe_din holds its value.
- The handshake that makes byte_cnt==cfg_len goes to DRAIN; s_ready drops the next cycle. No byte beyond cfg_len is ever accepted.
- Shift step: rot_cnt counts accepted bytes when rot_freq!=0. When rot_cnt reaches rot_freq-1 on a handshake, rot_cnt goes to 0 and pipe_shift_amt +1 (4-bit, 15 wraps to 0). The change is visible in the same cycle as the pipe_en of that byte's successor. rot_freq==0: pipe_shift_amt constant.
- DRAIN: load counter with PIPE_DEPTH on entry, decrement each cycle, go to DONE at 0. pipe_en=0 throughout.
- DONE: done=1 for exactly one cycle, then IDLE. byte_cnt and pipe config hold until the next config accept.
- cfg_valid in any state other than IDLE: ignored; cfg_ready=0.
- Reset mid-frame: immediate return to IDLE, outputs 0, no done pulse; the partial frame is discarded.

Optional Feature:
CTRL_ABORT_EN. Compiled in: extra input abort (1 bit). In RUN, abort=1 takes priority over a same-cycle handshake (that byte is not accepted). State goes to DRAIN, and done pulses with byte_cnt equal to the bytes actually accepted. Abort is ignored in IDLE, DRAIN and DONE. Compiled out: no abort port, and frames always run to cfg_len.

Decomposition:
- Package encrypt_pipe_pkg holds: ctrl_state_t enum {IDLE,RUN,DRAIN,DONE}, a config struct (mode, shift_en, shift_amt, k1..k3, rot_freq), and localparam BYTE_W=8 / SHIFT_W=4.
- One sub-module, encrypt_pipe_rot_ctr, holds rot_cnt plus the shift_amt stepping/wrap logic. Its inputs are load, init_amt, rot_freq and step (the handshake); its output is shift_amt.

Test Plan:
- Reset: drive rst=0 mid-RUN after 2 bytes -> all outputs 0 and cfg_ready=1 on the same edge; no done pulse.
- Basic frame: cfg_len=4, rot_freq=0, shift_amt=4, bytes 0x41..0x44 with s_valid always high -> pipe_en high for 4 cycles, each byte 1 cycle late; shift_amt stays 4; done pulses PIPE_DEPTH+1 cycles after the last pipe_en; byte_cnt=4.
- Backpressure/gaps: s_valid toggles 1,0,1,0 with cfg_len=3 -> pipe_en only on handshake cycles; exactly 3 bytes accepted; a 4th valid byte is not accepted (s_ready=0).
- Stepping with wrap: shift_amt=14, rot_freq=2, cfg_len=6 -> the bytes go in with shift_amt 14,14,15,15,0,0.
- Zero length: cfg_len=0 -> IDLE, DONE, IDLE; done one cycle after the config accept; pipe_en never asserted.
- Abort (CTRL_ABORT_EN): cfg_len=10, abort asserted on the same cycle as the 4th byte handshake -> byte_cnt=3, DRAIN, done pulses; the 4th byte never appears on pipe_din.
